bf2_sdf_stage: RTL and testbench

- Pipelined radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming 64-point FFT datapath.
- Takes one complex sample per valid cycle and pairs x[n] with x[n+DEPTH] through an internal delay line.
- Emits the DEPTH sums, then the DEPTH differences, in stream order.
- Extends the combinational butterfly with: a delay line, a frame counter, selectable overflow handling (wrap / saturate / scale-by-half with rounding), valid gating, and a sticky overflow flag.

---
 rtl/bf2_sdf_stage.sv | 157 +++++++++++++++
 tb/tb_bf2_sdf_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bf2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Pairs x[n] with x[n+DEPTH] through a circular delay line and emits the
// DEPTH sums of a frame followed (during the next frame) by its DEPTH
// differences. The overflow policy is latched at frame start.
module bf2_sdf_stage #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  input  logic [1:0]       mode,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             ovf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (AW > 0) ? AW : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0]      cnt_reg;
  logic [PW-1:0]      ptr_reg;
  logic [1:0]         mode_q_reg;
  logic               primed_reg;
  logic [2*WIDTH-1:0] dline [DEPTH];

  logic [2*WIDTH-1:0] rd_data;
  logic [2*WIDTH-1:0] wr_data;
  logic [2*WIDTH-1:0] cand;
  logic               phase;
  logic               ovf_any;

  // Lane 0 is the real part, lane 1 the imaginary part.
  logic [WIDTH-1:0] lane_a   [2];
  logic [WIDTH-1:0] lane_b   [2];
  logic [WIDTH-1:0] sum_res  [2];
  logic [WIDTH-1:0] diff_res [2];
  logic             sum_ovf  [2];
  logic             diff_ovf [2];

  // Reduce a (WIDTH+1)-bit sum/difference to WIDTH bits under the given
  // policy. Returns {overflow, result}. Mode 2 halves with round-half-up and
  // never reports overflow; modes 0 and 3 truncate (two's complement wrap).
  function automatic logic [WIDTH:0] fold(input logic [WIDTH:0] s,
                                          input logic [1:0]     md);
    logic [WIDTH:0]   r;
    logic             ovf;
    logic [WIDTH-1:0] res;
    r   = s + {{WIDTH{1'b0}}, 1'b1};
    ovf = s[WIDTH] ^ s[WIDTH-1];
    case (md)
      2'd1: begin
        if (ovf)
          res = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
          res = s[WIDTH-1:0];
      end
      2'd2: begin
        // Bits [WIDTH:1] of s+1 are exact even if s+1 wraps in WIDTH+1 bits.
        res = WIDTH'(r >> 1);
        ovf = 1'b0;
      end
      default: res = s[WIDTH-1:0];
    endcase
    return {ovf, res};
  endfunction

  assign rd_data   = dline[ptr_reg];
  assign phase     = cnt_reg[CW-1];
  assign lane_a[0] = rd_data[WIDTH-1:0];
  assign lane_a[1] = rd_data[2*WIDTH-1:WIDTH];
  assign lane_b[0] = in_re;
  assign lane_b[1] = in_im;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;
    logic [WIDTH:0] sum_f;
    logic [WIDTH:0] diff_f;
    assign sum_w        = {lane_a[gi][WIDTH-1], lane_a[gi]} + {lane_b[gi][WIDTH-1], lane_b[gi]};
    assign diff_w       = {lane_a[gi][WIDTH-1], lane_a[gi]} - {lane_b[gi][WIDTH-1], lane_b[gi]};
    assign sum_f        = fold(sum_w, mode_q_reg);
    assign diff_f       = fold(diff_w, mode_q_reg);
    assign sum_res[gi]  = sum_f[WIDTH-1:0];
    assign sum_ovf[gi]  = sum_f[WIDTH];
    assign diff_res[gi] = diff_f[WIDTH-1:0];
    assign diff_ovf[gi] = diff_f[WIDTH];
  end

  // Phase 0 stores the input and forwards the stored difference; phase 1
  // forwards the sum and stores the difference.
  always_comb begin
    cand    = rd_data;
    wr_data = {in_im, in_re};
    ovf_any = 1'b0;
    if (phase) begin
      cand    = {sum_res[1], sum_res[0]};
      wr_data = {diff_res[1], diff_res[0]};
      ovf_any = sum_ovf[0] | sum_ovf[1] | diff_ovf[0] | diff_ovf[1];
    end
  end

  // Frame counter, delay-line pointer, latched mode and primed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      mode_q_reg <= 2'd0;
      primed_reg <= 1'b0;
    end else if (in_valid) begin
      cnt_reg <= cnt_reg + CW'(1);
      ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PW'(1);
      if (cnt_reg == '0)
        mode_q_reg <= mode;
      if (phase)
        primed_reg <= 1'b1;
    end
  end

  // Delay line: the old entry is consumed combinationally before this write.
  always_ff @(posedge clk) begin
    if (in_valid)
      dline[ptr_reg] <= wr_data;
  end

  // Output register: one-cycle latency, data holds while not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (in_valid && (primed_reg || phase)) begin
      out_valid <= 1'b1;
      out_re    <= cand[WIDTH-1:0];
      out_im    <= cand[2*WIDTH-1:WIDTH];
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (in_valid && phase && ovf_any)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Self-checking bench for bf2_sdf_stage with DEPTH=4, WIDTH=17.
// A frame-level reference model pushes expected outputs into a scoreboard
// queue when stimulus is driven; they are popped when out_valid appears.
module tb_bf2_sdf_stage;

  localparam int W = 17;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic [1:0]   mode = 2'd0;
  logic         ovf_clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic         ovf_sticky;

  bf2_sdf_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .mode       (mode),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .out_re     (out_re),
    .out_im     (out_im),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int  m_cnt = 0;
  bit  m_primed = 0;
  bit  m_sticky = 0;
  int  m_mode = 0;
  bit  gaps = 0;
  int  aq_re[$], aq_im[$];   // phase-0 samples awaiting their partner
  int  dq_re[$], dq_im[$];   // differences awaiting the next phase 0
  int  eq_re[$], eq_im[$];   // scoreboard of expected outputs

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int wrap_w(input int s);
    int r;
    r = s & ((1 << W) - 1);
    if (r >= (1 << (W - 1))) r = r - (1 << W);
    return r;
  endfunction

  function automatic int fold_model(input int s, input int md, output bit ov);
    int hi, lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    ov = 1'b0;
    if (md == 2) return wrap_w((s + 1) >>> 1);
    ov = (s > hi) || (s < lo);
    if (md == 1) return (s > hi) ? hi : ((s < lo) ? lo : s);
    return wrap_w(s);
  endfunction

  // One clock cycle: drive, update the model, then sample 1 time unit after the edge.
  task automatic step(input bit v, input int re, input int im, input bit clr);
    bit exp_v, o1, o2, o3, o4;
    int a_re, a_im, ore, oim;
    @(negedge clk);
    in_valid = v;
    in_re    = W'(re);
    in_im    = W'(im);
    ovf_clr  = clr;
    exp_v    = 1'b0;
    if (clr) m_sticky = 1'b0;
    if (v) begin
      if (m_cnt == 0) m_mode = int'(mode);
      if (m_cnt < D) begin
        if (m_primed && dq_re.size() > 0) begin
          exp_v = 1'b1;
          eq_re.push_back(dq_re.pop_front());
          eq_im.push_back(dq_im.pop_front());
        end
        aq_re.push_back(re);
        aq_im.push_back(im);
      end else begin
        a_re = aq_re.pop_front();
        a_im = aq_im.pop_front();
        eq_re.push_back(fold_model(a_re + re, m_mode, o1));
        eq_im.push_back(fold_model(a_im + im, m_mode, o2));
        dq_re.push_back(fold_model(a_re - re, m_mode, o3));
        dq_im.push_back(fold_model(a_im - im, m_mode, o4));
        if (o1 || o2 || o3 || o4) m_sticky = 1'b1;
        m_primed = 1'b1;
        exp_v    = 1'b1;
      end
      m_cnt = (m_cnt + 1) % (2 * D);
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", int'(out_valid), int'(exp_v));
    if (out_valid) begin
      if (eq_re.size() == 0) begin
        check_eq("unexpected_output", 1, 0);
      end else begin
        ore = eq_re.pop_front();
        oim = eq_im.pop_front();
        check_eq("out_re", int'($signed(out_re)), ore);
        check_eq("out_im", int'($signed(out_im)), oim);
      end
    end
    check_eq("ovf_sticky", int'(ovf_sticky), int'(m_sticky));
  endtask

  task automatic feed(input int re, input int im);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1)
        step(1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b0);
    end
    step(1'b1, re, im, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_re", int'(out_re), 0);
    check_eq("rst_out_im", int'(out_im), 0);
    check_eq("rst_ovf_sticky", int'(ovf_sticky), 0);
    check_eq("sb_drain", eq_re.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_primed = 0; m_sticky = 0; m_mode = 0;
    aq_re.delete(); aq_im.delete(); dq_re.delete(); dq_im.delete();
    eq_re.delete(); eq_im.delete();
  endtask

  task automatic ramp_stream();
    for (int i = 1; i <= 2 * D; i++) feed(i, 0);
    for (int i = 0; i < D; i++) feed(0, 0);
  endtask

  task automatic ovf_frame(input bit clr_first);
    feed(65535, 5);  feed(-65536, -5); feed(0, 0); feed(0, 0);
    feed(65535, 7);  feed(1, -7);      feed(0, 0); feed(0, 0);
    step(1'b1, 0, 0, clr_first);
    for (int i = 1; i < D; i++) feed(0, 0);
  endtask

  initial begin
    // Scenario 1: ramp, wrap mode
    do_reset();
    mode = 2'd0;
    ramp_stream();

    // Scenario 2: saturation
    do_reset();
    mode = 2'd1;
    ovf_frame(1'b0);

    // Scenario 3: wrap with overflow, then clear the flag
    do_reset();
    mode = 2'd0;
    ovf_frame(1'b1);

    // Scenario 4: scale by half with round-half-up
    do_reset();
    mode = 2'd2;
    feed(3, -3); feed(-3, 3); feed(0, 0); feed(0, 0);
    feed(4, -4); feed(-4, 4); feed(0, 0); feed(0, 0);
    for (int i = 0; i < D; i++) feed(0, 0);

    // Scenario 5: random valid gaps
    do_reset();
    mode = 2'd0;
    gaps = 1'b1;
    ramp_stream();
    gaps = 1'b0;

    // Scenario 6: reset mid-phase-1, replay, mode change mid-frame
    do_reset();
    mode = 2'd0;
    for (int i = 1; i <= 6; i++) feed(i, 0);
    do_reset();
    mode = 2'd0;
    feed(1, 0);
    feed(2, 0);
    mode = 2'd2;
    for (int i = 3; i <= 2 * D; i++) feed(i, 0);
    for (int i = 0; i < 2 * D; i++) feed(0, 0);

    check_eq("sb_final_drain", eq_re.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
